// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the fifo_level buffer and its pointer sub-block.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Pointer must index DEPTH entries; keep at least one bit for degenerate sizes.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count must represent 0..DEPTH inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping circular-buffer pointer: advances on en, wraps DEPTH-1 -> 0 for any DEPTH.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_level.sv
// Single-clock FIFO with any depth, standard or first-word-fall-through reads,
// occupancy count, programmable almost flags and registered overflow/underflow pulses.
module fifo_level
  import fifo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 32,
  parameter int FWFT          = FIFO_MODE_STD,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1,
  parameter int PTR_W         = ptr_width(DEPTH),
  parameter int CNT_W         = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             almost_full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             almost_empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  // Handshake: a request is taken only when the registered flag allows it
  // (wr_en & !full, rd_en & !empty); a refused request leaves data state
  // untouched and raises a one-cycle error pulse on the following cycle.
  logic             wr_acc;
  logic             rd_acc;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_W'(AFULL_THRESH));
  assign almost_empty = (count <= CNT_W'(AEMPTY_THRESH));

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .en  (wr_acc),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .en  (rd_acc),
    .ptr (rd_ptr)
  );

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is visible as soon as count leaves zero; meaningless while empty.
      assign dout = mem[rd_ptr];
    end else begin : g_std
      logic [WIDTH-1:0] dout_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q <= '0;
        end else if (rd_acc) begin
          dout_q <= mem[rd_ptr];
        end
      end
      assign dout = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_level.sv
// Bench for fifo_level: four configurations share one directed stimulus stream and
// are checked every cycle against a sequence-history model plus literal pin checks.
module tb_fifo_level;

  localparam int N = 4;
  localparam int DEP [N] = '{4, 5, 4, 8};
  localparam int FW  [N] = '{0, 0, 1, 0};
  localparam int AFT [N] = '{2, 3, 2, 6};
  localparam int AET [N] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] din = 8'h00;

  logic       full_a  [N];
  logic       af_a    [N];
  logic       empty_a [N];
  logic       ae_a    [N];
  logic       ovf_a   [N];
  logic       unf_a   [N];
  logic [7:0] dout_a  [N];
  logic [3:0] cnt_a   [N];
  logic [2:0] cnt0, cnt1, cnt2;
  logic [3:0] cnt3;

  assign cnt_a[0] = {1'b0, cnt0};
  assign cnt_a[1] = {1'b0, cnt1};
  assign cnt_a[2] = {1'b0, cnt2};
  assign cnt_a[3] = cnt3;

  always #5 clk = ~clk;

  fifo_level #(.WIDTH(8), .DEPTH(4), .FWFT(0), .AFULL_THRESH(2), .AEMPTY_THRESH(1)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(full_a[0]), .almost_full(af_a[0]),
    .rd_en(rd_en), .dout(dout_a[0]), .empty(empty_a[0]), .almost_empty(ae_a[0]),
    .count(cnt0), .overflow(ovf_a[0]), .underflow(unf_a[0]));

  fifo_level #(.WIDTH(8), .DEPTH(5), .FWFT(0), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(full_a[1]), .almost_full(af_a[1]),
    .rd_en(rd_en), .dout(dout_a[1]), .empty(empty_a[1]), .almost_empty(ae_a[1]),
    .count(cnt1), .overflow(ovf_a[1]), .underflow(unf_a[1]));

  fifo_level #(.WIDTH(8), .DEPTH(4), .FWFT(1), .AFULL_THRESH(2), .AEMPTY_THRESH(1)) u2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(full_a[2]), .almost_full(af_a[2]),
    .rd_en(rd_en), .dout(dout_a[2]), .empty(empty_a[2]), .almost_empty(ae_a[2]),
    .count(cnt2), .overflow(ovf_a[2]), .underflow(unf_a[2]));

  fifo_level #(.WIDTH(8), .DEPTH(8), .FWFT(0), .AFULL_THRESH(6), .AEMPTY_THRESH(2)) u3 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(full_a[3]), .almost_full(af_a[3]),
    .rd_en(rd_en), .dout(dout_a[3]), .empty(empty_a[3]), .almost_empty(ae_a[3]),
    .count(cnt3), .overflow(ovf_a[3]), .underflow(unf_a[3]));

  // Model: every accepted word is appended to an unbounded history; occupancy is tail-head.
  int         head [N];
  int         tail [N];
  logic [7:0] hist [N][256];
  logic [7:0] dm   [N];
  logic       ovm  [N];
  logic       unm  [N];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      head[i] = tail[i];
      dm[i]   = 8'h00;
      ovm[i]  = 1'b0;
      unm[i]  = 1'b0;
    end
  endtask

  task automatic model_step(input logic w, input logic r, input logic [7:0] d);
    for (int i = 0; i < N; i++) begin
      int  occ;
      logic was_full, was_empty;
      occ       = tail[i] - head[i];
      was_full  = (occ == DEP[i]);
      was_empty = (occ == 0);
      ovm[i] = w & was_full;
      unm[i] = r & was_empty;
      if (r && !was_empty) begin
        if (FW[i] == 0) dm[i] = hist[i][head[i] & 255];
        head[i]++;
      end
      if (w && !was_full) begin
        hist[i][tail[i] & 255] = d;
        tail[i]++;
      end
    end
  endtask

  // One bus cycle: inputs held across the rising edge, model advanced after it.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    model_step(w, r, d);
    @(negedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      int occ;
      occ = tail[i] - head[i];
      chk($sformatf("u%0d.count", i), int'(cnt_a[i]), occ);
      chk($sformatf("u%0d.full", i), int'(full_a[i]), int'(occ == DEP[i]));
      chk($sformatf("u%0d.empty", i), int'(empty_a[i]), int'(occ == 0));
      chk($sformatf("u%0d.almost_full", i), int'(af_a[i]), int'(occ >= AFT[i]));
      chk($sformatf("u%0d.almost_empty", i), int'(ae_a[i]), int'(occ <= AET[i]));
      chk($sformatf("u%0d.overflow", i), int'(ovf_a[i]), int'(ovm[i]));
      chk($sformatf("u%0d.underflow", i), int'(unf_a[i]), int'(unm[i]));
      if (FW[i] == 0) begin
        chk($sformatf("u%0d.dout", i), int'(dout_a[i]), int'(dm[i]));
      end else if (occ != 0) begin
        chk($sformatf("u%0d.dout_head", i), int'(dout_a[i]), int'(hist[i][head[i] & 255]));
      end
    end
  end

  initial begin
    logic [7:0] wrap_exp [4];
    logic [7:0] fill_ae, fill_af, drain_ae, drain_af;

    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    model_reset();

    // Reset then idle
    @(negedge clk);
    #1;
    do_reset();
    cyc(1'b0, 1'b0, 8'h00);
    chk("pin.reset_count", int'(cnt0), 0);
    chk("pin.reset_empty", int'(empty_a[0]), 1);
    chk("pin.reset_aempty", int'(ae_a[0]), 1);
    chk("pin.reset_full", int'(full_a[0]), 0);
    chk("pin.reset_dout", int'(dout_a[0]), 0);

    // Fill depth-4 to full, then overflow
    cyc(1'b1, 1'b0, 8'hA1);
    cyc(1'b1, 1'b0, 8'hB2);
    cyc(1'b1, 1'b0, 8'hC3);
    cyc(1'b1, 1'b0, 8'hD4);
    chk("pin.fill_count", int'(cnt0), 4);
    chk("pin.fill_full", int'(full_a[0]), 1);
    cyc(1'b1, 1'b0, 8'hE5);
    chk("pin.ovf_pulse", int'(ovf_a[0]), 1);
    chk("pin.ovf_count", int'(cnt0), 4);
    chk("pin.d5_count", int'(cnt1), 5);
    cyc(1'b0, 1'b0, 8'h00);
    chk("pin.ovf_clear", int'(ovf_a[0]), 0);

    // Read and write together while full: read wins, write is refused
    cyc(1'b1, 1'b1, 8'hF6);
    chk("pin.full_both_count", int'(cnt0), 3);
    chk("pin.full_both_ovf", int'(ovf_a[0]), 1);
    chk("pin.full_both_dout", int'(dout_a[0]), 8'hA1);
    cyc(1'b0, 1'b1, 8'h00);
    chk("pin.rd_b2", int'(dout_a[0]), 8'hB2);
    cyc(1'b0, 1'b1, 8'h00);
    chk("pin.rd_c3", int'(dout_a[0]), 8'hC3);
    cyc(1'b0, 1'b1, 8'h00);
    chk("pin.rd_d4", int'(dout_a[0]), 8'hD4);
    chk("pin.drained_empty", int'(empty_a[0]), 1);

    // Read while empty
    cyc(1'b0, 1'b1, 8'h00);
    chk("pin.unf_pulse", int'(unf_a[0]), 1);
    chk("pin.unf_dout_hold", int'(dout_a[0]), 8'hD4);
    chk("pin.d5_last", int'(dout_a[1]), 8'hE5);

    // Both at empty: write taken, read refused
    cyc(1'b1, 1'b1, 8'h77);
    chk("pin.empty_both_count", int'(cnt0), 1);
    chk("pin.empty_both_unf", int'(unf_a[0]), 1);

    // Both at count 2: count holds
    cyc(1'b1, 1'b0, 8'h88);
    cyc(1'b1, 1'b1, 8'h99);
    chk("pin.mid_both_count", int'(cnt0), 2);
    chk("pin.mid_both_dout", int'(dout_a[0]), 8'h77);

    // Asynchronous reset mid-fill
    cyc(1'b1, 1'b0, 8'hAA);
    rst = 1'b1;
    #1;
    chk("pin.async_count", int'(cnt0), 0);
    chk("pin.async_empty", int'(empty_a[0]), 1);
    chk("pin.async_dout", int'(dout_a[0]), 0);
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;

    // FWFT: head appears without a read request
    cyc(1'b1, 1'b0, 8'h3C);
    chk("pin.fwft_empty", int'(empty_a[2]), 0);
    chk("pin.fwft_dout", int'(dout_a[2]), 8'h3C);
    cyc(1'b0, 1'b1, 8'h00);
    chk("pin.fwft_pop_empty", int'(empty_a[2]), 1);

    // Depth-5 wrap with interleaved reads
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, (k % 3) == 2, 8'h10 + 8'(k));
    end
    chk("pin.wrap_count", int'(cnt1), 4);
    chk("pin.wrap_dout", int'(dout_a[1]), 8'h13);
    wrap_exp[0] = 8'h14;
    wrap_exp[1] = 8'h15;
    wrap_exp[2] = 8'h16;
    wrap_exp[3] = 8'h19;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk($sformatf("pin.wrap_rd%0d", k), int'(dout_a[1]), int'(wrap_exp[k]));
    end

    // Threshold walk on depth-8 (afull 6, aempty 2)
    do_reset();
    fill_ae  = 8'b0000_0011;  // bit j: count j+1 after fill step j
    fill_af  = 8'b1110_0000;
    drain_ae = 8'b1110_0000;  // bit j: count 7-j after drain step j
    drain_af = 8'b0000_0011;
    for (int j = 0; j < 8; j++) begin
      cyc(1'b1, 1'b0, 8'h40 + 8'(j));
      chk($sformatf("pin.fill%0d_ae", j), int'(ae_a[3]), int'(fill_ae[j]));
      chk($sformatf("pin.fill%0d_af", j), int'(af_a[3]), int'(fill_af[j]));
    end
    for (int j = 0; j < 8; j++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk($sformatf("pin.drain%0d_ae", j), int'(ae_a[3]), int'(drain_ae[j]));
      chk($sformatf("pin.drain%0d_af", j), int'(af_a[3]), int'(drain_af[j]));
    end

    // Pseudo-random tail of traffic for the per-cycle model
    for (int k = 0; k < 60; k++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    cyc(1'b0, 1'b0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_level.md
Name: fifo_level

Overview:
- Next-generation synchronous FIFO: one clock, parametrised width and depth, with no power-of-two restriction on depth.
- Selectable read mode:
  - standard: registered dout, 1-cycle read latency.
  - first-word-fall-through (FWFT): head word presented on dout.
- Adds an occupancy count, programmable almost-full/almost-empty flags, and overflow/underflow error pulses.
- Drop-in buffer between producer/consumer stages of the datapath.

Parameters:
- WIDTH, 8: data word width in bits, >=1.
- DEPTH, 32: number of entries, >=2, any integer.
- FWFT, 0: 0 = standard read mode, 1 = first-word-fall-through.
- AFULL_THRESH, DEPTH-2: almost_full asserted when count >= AFULL_THRESH; legal range 1..DEPTH.
- AEMPTY_THRESH, 1: almost_empty asserted when count <= AEMPTY_THRESH; legal range 0..DEPTH-1.
- PTR_W, $clog2(DEPTH): pointer width.
- CNT_W, $clog2(DEPTH+1): count width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write request.
- din  in  WIDTH  write data.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_THRESH.
- rd_en  in  1  read request (standard mode) / pop (FWFT mode).
- dout  out  WIDTH  read data.
- empty  out  1  count == 0.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- overflow  out  1  1-cycle pulse: write attempted while full.
- underflow  out  1  1-cycle pulse: read attempted while empty.

Behaviour:
- Reset (async assert, state takes effect immediately):
  - Pointers = 0, count = 0, dout = 0, overflow = 0, underflow = 0.
  - Hence empty = 1, almost_empty = 1, full = 0.
  - almost_full = 0 (AFULL_THRESH >= 1).
  - Memory contents are not reset.
- Accept rules, evaluated on state at the clock edge:
  - wr_acc = wr_en & !full.
  - rd_acc = rd_en & !empty.
  - No write-through when full; no read-through when empty.
  - Full with both asserted: read accepted, write rejected (overflow pulses).
  - Empty with both asserted: write accepted, read rejected (underflow pulses).
- Pointer update:
  - wr_acc: mem[wr_ptr] <= din.
  - Each pointer advances on its accept and wraps from DEPTH-1 to 0 explicitly; no reliance on natural overflow.
- Count update:
  - +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- Flags: full, empty, almost_full and almost_empty are decoded from the registered count only; no combinational path from wr_en/rd_en.
- Standard mode (FWFT=0):
  - rd_acc at edge N: dout <= mem[rd_ptr], valid after edge N.
  - dout holds its value when no rd_acc.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] combinationally while !empty; rd_acc pops the head.
  - A word written at edge N into an empty FIFO appears on dout with empty = 0 after edge N.
  - dout is don't-care while empty.
- Error pulses:
  - overflow <= wr_en & full.
  - underflow <= rd_en & empty.
  - Both registered, high for exactly one cycle per offending cycle; no other state changes.
- Reset asserted mid-operation: all state returns to reset values within the same cycle; queued data is discarded.

Decomposition:
- Package fifo_pkg holds:
  - Mode constants FIFO_MODE_STD = 0, FIFO_MODE_FWFT = 1.
  - Width helper functions for PTR_W and CNT_W.
- Sub-module fifo_ptr (parameter DEPTH):
  - Wrapping pointer with enable and async reset.
  - Instantiated twice, for the read and write pointers.

Test Plan:
1. Reset then idle, DEPTH=4 -> count = 0, empty = 1, almost_empty = 1, full = 0, dout = 0; assert rst mid-fill -> same values immediately.
2. STD, DEPTH=4: write 0xA1, 0xB2, 0xC3, 0xD4 -> full = 1, count = 4; 5th write 0xE5 -> overflow pulses 1 cycle, count stays 4; four reads -> dout = A1, B2, C3, D4, each one cycle after its rd_en.
3. DEPTH=5 (non-power-of-two), 12 writes interleaved with reads -> data order preserved across pointer wrap at 4->0; count never exceeds 5.
4. FWFT=1: write 0x3C into empty FIFO -> next cycle empty = 0 and dout = 0x3C before any rd_en; rd_en -> empty = 1 next cycle.
5. Simultaneous wr_en & rd_en at count = 2 -> count stays 2; same at count = 0 -> count becomes 1, underflow pulses; same at full -> count = DEPTH-1, overflow pulses.
6. DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=2:
   - Fill 0->8 -> almost_empty deasserts at count = 3, almost_full asserts at count = 6.
   - Drain -> almost_full deasserts at count = 5, almost_empty asserts at count = 2.
